gpu_op_arbiter: RTL and testbench
=================================

Name: gpu_op_arbiter

Overview:
- Shares the single rectangle-draw GPU op port between REQUESTERS independent op sources, e.g. the game controller, a score/overlay drawer and a debug overlay.
- Uses round-robin arbitration.
- Reproduces the GPU-side protocol exactly: a one-cycle op_valid pulse, then a wait for op_ready.
- Tracks per-requester end-of-frame so the frame is handed to the buffer-swap logic only after every source has drawn.

Parameters:
REQUESTERS, 2, number of op sources (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; all state advances only when ce=1
req_op  in  REQUESTERS x gpu_op_t  op from each requester
req_last  in  REQUESTERS  req_op[i] is requester i's final op this frame
req_valid  in  REQUESTERS  requester i has an op pending
req_ready  out  REQUESTERS  op i accepted this cycle (combinational)
gpu_op  out  gpu_op_t  op to GPU (registered)
gpu_op_valid  out  1  one-cycle issue pulse to GPU
gpu_op_ready  in  1  GPU idle / able to take op
frame_done  out  1  all requesters finished; frame complete
swap  in  1  buffer swap occurred; starts a new frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE
  - gpu_op='0, gpu_op_valid=0, frame_done=0
  - done_mask='0
  - last_grant=REQUESTERS-1, so requester 0 has first priority.
- Eligible requester i: req_valid[i]=1 and done_mask[i]=0.
- Winner: the first eligible index searching last_grant+1, last_grant+2, ... modulo REQUESTERS.
- State IDLE:
  - A winner is accepted when ce=1, gpu_op_ready=1, at least one eligible requester exists and frame_done=0.
  - req_ready[winner]=1 in that same cycle; all other req_ready are 0. req_ready=0 in every other state.
  - On the accept edge: gpu_op<=req_op[winner], gpu_op_valid<=1, last_grant<=winner, done_mask[winner]<=req_last[winner], state<=WAIT_1.
- State WAIT_1: gpu_op_valid<=0; state<=WAIT_2. This gives the GPU one cycle to drop gpu_op_ready.
- State WAIT_2: when gpu_op_ready=1, state<=IDLE.
- Latency: an op accepted at edge N appears with gpu_op_valid high for exactly cycle N+1. The next accept is at the earliest edge N+3.
- gpu_op holds its value until the next accept.
- Frame completion:
  - In IDLE with done_mask all-ones and gpu_op_ready=1, set frame_done<=1. The last op must have finished before the frame is reported.
  - frame_done stays high until swap.
- Swap:
  - swap=1 with ce=1 while frame_done=1: frame_done<=0 and done_mask<='0 on the same edge. last_grant is kept.
  - swap while frame_done=0 is ignored and has no effect.
- Simultaneous events:
  - A requester whose done_mask bit is set is skipped even if req_valid=1; it stalls until the next frame.
  - Same-cycle accept and swap cannot occur: accept requires frame_done=0, and swap is only honoured with frame_done=1.
- ce=0: all registers hold, req_ready=0, and gpu_op_valid is held as well. The GPU shares ce, so the pulse still lasts exactly one enabled cycle.
- Reset mid-operation: asynchronously drops gpu_op_valid and frame_done and abandons any op in flight. Requesters re-present their ops after reset.
- req_op is sampled only on the accept edge. It must be stable while req_valid=1.

Test Plan:
- Single requester, 3 ops (last on the 3rd), GPU ready drops 1 cycle after each pulse for 10 cycles:
  - each gpu_op_valid is a 1-cycle pulse carrying the correct op;
  - accepts are spaced >=12 cycles;
  - frame_done rises only after ready returns following op 3.
- REQUESTERS=3, all valid continuously, GPU always ready: grants are 0,1,2,0,1,2 with accepts exactly every 3 cycles.
- Requester 0 sends last on its first op while 1 keeps sending: 0 is never granted again until swap; frame_done rises only after requester 1's last op.
- swap pulse while frame_done=0: no change. swap while frame_done=1: frame_done=0 and done_mask cleared next cycle; grants resume at last_grant+1.
- ce toggling 1/0 every cycle during traffic: op order and gpu_op contents match the ce=1 run, and gpu_op_valid spans exactly one enabled cycle.
- Assert rst_n low during WAIT_2 of an op:
  - gpu_op_valid=0, frame_done=0, state IDLE immediately;
  - after release, requester 0 is granted first.

Source files
------------

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing one rectangle-draw GPU op port between several op sources,
// with per-source end-of-frame tracking ahead of the buffer swap.

package gpu_op_pkg;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COLOR_W-1:0] color;
  } gpu_op_t;
endpackage

module gpu_op_arbiter
  import gpu_op_pkg::*;
#(
  parameter int unsigned REQUESTERS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  gpu_op_t [REQUESTERS-1:0] req_op,
  input  logic [REQUESTERS-1:0]    req_last,
  input  logic [REQUESTERS-1:0]    req_valid,
  output logic [REQUESTERS-1:0]    req_ready,
  output gpu_op_t                  gpu_op,
  output logic                     gpu_op_valid,
  input  logic                     gpu_op_ready,
  output logic                     frame_done,
  input  logic                     swap
);

  localparam int unsigned IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_1 = 2'd1,
    WAIT_2 = 2'd2
  } state_e;

  state_e                  state_q;
  gpu_op_t                 gpu_op_q;
  logic                    gpu_op_valid_q;
  logic                    frame_done_q;
  logic [REQUESTERS-1:0]   done_mask_q;
  logic [IW-1:0]           last_grant_q;

  logic [REQUESTERS-1:0]   eligible;
  logic                    win_found;
  logic [IW-1:0]           win_idx;
  logic [IW-1:0]           cand;
  logic                    accept;

  // Rotating search starting just after the previous grant.
  always_comb begin
    eligible  = req_valid & ~done_mask_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      cand = IW'((32'(last_grant_q) + k) % REQUESTERS);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    accept    = ce && (state_q == IDLE) && gpu_op_ready && win_found && !frame_done_q;
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      gpu_op_q       <= '0;
      gpu_op_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      done_mask_q    <= '0;
      last_grant_q   <= IW'(REQUESTERS - 1);
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            gpu_op_q             <= req_op[win_idx];
            gpu_op_valid_q       <= 1'b1;
            last_grant_q         <= win_idx;
            done_mask_q[win_idx] <= req_last[win_idx];
            state_q              <= WAIT_1;
          end else if (frame_done_q && swap) begin
            frame_done_q <= 1'b0;
            done_mask_q  <= '0;
          end else if ((&done_mask_q) && gpu_op_ready) begin
            // Frame is reported only once the GPU has finished the final op.
            frame_done_q <= 1'b1;
          end
        end
        WAIT_1: begin
          gpu_op_valid_q <= 1'b0;
          state_q        <= WAIT_2;
        end
        WAIT_2: begin
          if (gpu_op_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gpu_op       = gpu_op_q;
  assign gpu_op_valid = gpu_op_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Bench for gpu_op_arbiter: randomized requester/GPU traffic compared every cycle against
// a behavioural arbitration model, plus scenario checks on order, spacing, frames and reset.

module tb_gpu_op_arbiter;
  import gpu_op_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned VW = N + 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ce = 1'b0;
  gpu_op_t [N-1:0]   req_op = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  gpu_op_t           gpu_op;
  logic              gpu_op_valid;
  logic              gpu_op_ready = 1'b1;
  logic              frame_done;
  logic              swap = 1'b0;

  gpu_op_arbiter #(.REQUESTERS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .req_op       (req_op),
    .req_last     (req_last),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .gpu_op       (gpu_op),
    .gpu_op_valid (gpu_op_valid),
    .gpu_op_ready (gpu_op_ready),
    .frame_done   (frame_done),
    .swap         (swap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    gpu_op_t op;
    logic    last;
  } item_t;

  item_t   rq [N][$];
  item_t   pat [N][3];
  gpu_op_t got [$];
  gpu_op_t got_a [$];
  int      n_vec, n_miss;
  int      gpu_busy, busy_len;
  int      g_last, n_acc, n_ven;

  // Reference model: protocol phase 0 = pulse cycle, 1 = waiting for GPU, 2 = free to grant.
  int          m_last, m_phase;
  logic [N-1:0] m_done;
  logic        m_valid, m_frame;
  gpu_op_t     m_op;

  function automatic void m_reset();
    m_last = N - 1; m_phase = 2; m_done = '0;
    m_valid = 1'b0; m_frame = 1'b0; m_op = '0;
  endfunction

  function automatic int m_pick();
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (req_valid[i] && !m_done[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    int w = m_pick();
    if (ce && m_phase == 2 && gpu_op_ready && !m_frame && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic void m_step();
    int w;
    if (!ce) return;
    w = m_pick();
    if (m_phase == 0) begin
      m_valid = 1'b0; m_phase = 1;
    end else if (m_phase == 1) begin
      if (gpu_op_ready) m_phase = 2;
    end else if (m_ready() != '0) begin
      m_op = req_op[w]; m_valid = 1'b1; m_last = w; m_phase = 0;
      if (req_last[w]) m_done[w] = 1'b1;
    end else if (m_frame && swap) begin
      m_frame = 1'b0; m_done = '0;
    end else if (m_done == '1 && gpu_op_ready) begin
      m_frame = 1'b1;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_ready(), m_valid, m_frame, m_op};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {req_ready, gpu_op_valid, frame_done, gpu_op};
  endfunction

  function automatic gpu_op_t rand_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return gpu_op_t'(r[47:0]);
  endfunction

  function automatic void push_op(int i, logic last);
    item_t it;
    it.op = rand_op(); it.last = last;
    rq[i].push_back(it);
  endfunction

  // Present queue heads and GPU readiness, then let combinational outputs settle.
  task automatic tick_pre();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_op[i]    = req_valid[i] ? rq[i][0].op : '0;
      req_last[i]  = req_valid[i] ? rq[i][0].last : 1'b0;
    end
    gpu_op_ready = (gpu_busy == 0);
    #1;
  endtask

  // Advance the model over the coming edge, retire granted ops, and run the GPU busy timer.
  task automatic tick_post();
    m_step();
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        rq[i].delete(0);
        g_last = i;
      end
    end
    if (ce) begin
      if (gpu_busy > 0) gpu_busy--;
      if (gpu_op_valid) gpu_busy = busy_len;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ce = 1'b0; swap = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    m_reset(); gpu_busy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0; ce = 1'b1; swap = 1'b0; busy_len = 0; gpu_busy = 0;
    m_reset();
    tick_pre();
    n_vec++;
    if ({gpu_op_valid, frame_done} !== 2'b00) begin
      n_miss++; $display("FAIL reset_flags: got %b want 00", {gpu_op_valid, frame_done});
    end
    n_vec++;
    if (gpu_op !== gpu_op_t'('0)) begin
      n_miss++; $display("FAIL reset_op: got %h want 0", gpu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) push_op(i, 1'b0);
    tick_pre();
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_miss++; $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL reset_model: dut %h model %h", obs_vec(), exp_vec());
    end
    tick_post();
  endtask

  task automatic test_round_robin();
    int gi = 0;
    int prev = -1;
    do_reset(); ce = 1'b1; busy_len = 0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) push_op(i, 1'b0);
    for (int c = 0; c < 40 && gi < 6; c++) begin
      swap = ($urandom_range(0, 3) == 0);
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL rr cyc %0d: dut %h model %h", c, obs_vec(), exp_vec());
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          n_vec++;
          if (i != gi % 3) begin
            n_miss++; $display("FAIL rr_order grant %0d: got %0d want %0d", gi, i, gi % 3);
          end
          if (gi > 0) begin
            n_vec++;
            if (c - prev != 3) begin
              n_miss++; $display("FAIL rr_spacing grant %0d: got %0d want 3", gi, c - prev);
            end
          end
          prev = c; gi++;
        end
      end
      tick_post();
    end
    swap = 1'b0;
    n_vec++;
    if (gi != 6) begin
      n_miss++; $display("FAIL rr_count: got %0d want 6", gi);
    end
  endtask

  task automatic test_single();
    int a0[$];
    int f = -1;
    busy_len = 10; swap = 1'b0;
    push_op(1, 1'b1); push_op(2, 1'b1);
    push_op(0, 1'b0); push_op(0, 1'b0); push_op(0, 1'b1);
    for (int c = 0; c < 150 && f < 0; c++) begin
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL single cyc %0d: dut %h model %h", c, obs_vec(), exp_vec());
      end
      if (req_ready[0]) a0.push_back(c);
      if (frame_done && f < 0) f = c;
      tick_post();
    end
    n_vec++;
    if (a0.size() != 3) begin
      n_miss++; $display("FAIL single_count: got %0d want 3", a0.size());
    end
    for (int k = 1; k < a0.size(); k++) begin
      n_vec++;
      if (a0[k] - a0[k-1] < 12) begin
        n_miss++; $display("FAIL single_spacing %0d: got %0d want >=12", k, a0[k] - a0[k-1]);
      end
    end
    n_vec++;
    if (a0.size() < 3 || f != a0[a0.size()-1] + 14) begin
      n_miss++; $display("FAIL single_frame: frame_done at %0d want 14 after last accept", f);
    end
  endtask

  task automatic test_swap();
    int exp_first = (g_last + 1) % N;
    busy_len = 2;
    for (int i = 0; i < N; i++) push_op(i, 1'b0);
    swap = 1'b0;
    tick_pre();
    n_vec++;
    if (frame_done !== 1'b1 || req_ready !== '0) begin
      n_miss++; $display("FAIL swap_hold: got fd=%b rdy=%b want fd=1 rdy=000", frame_done, req_ready);
    end
    tick_post();
    swap = 1'b1;
    tick_pre();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL swap_edge: dut %h model %h", obs_vec(), exp_vec());
    end
    tick_post();
    swap = 1'b0;
    tick_pre();
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_miss++; $display("FAIL swap_clear: got %b want 0", frame_done);
    end
    n_vec++;
    if (req_ready !== N'(1 << exp_first)) begin
      n_miss++; $display("FAIL swap_resume: got %b want %b", req_ready, N'(1 << exp_first));
    end
    tick_post();
    for (int c = 0; c < 30; c++) begin
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL swap cyc %0d: dut %h model %h", c, obs_vec(), exp_vec());
      end
      tick_post();
    end
  endtask

  task automatic test_stall();
    int n0 = 0;
    int r1 = -1;
    int f = -1;
    busy_len = 1;
    push_op(0, 1'b1); push_op(0, 1'b0);
    for (int k = 0; k < 3; k++) push_op(1, 1'b0);
    push_op(1, 1'b1); push_op(2, 1'b1);
    for (int c = 0; c < 120 && f < 0; c++) begin
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL stall cyc %0d: dut %h model %h", c, obs_vec(), exp_vec());
      end
      if (req_ready[0]) n0++;
      if (req_ready[1] && req_last[1]) r1 = c;
      if (frame_done && f < 0) f = c;
      tick_post();
    end
    n_vec++;
    if (n0 != 1) begin
      n_miss++; $display("FAIL stall_grants0: got %0d want 1", n0);
    end
    n_vec++;
    if (r1 < 0 || f <= r1) begin
      n_miss++; $display("FAIL stall_frame: frame_done at %0d, req1 last at %0d", f, r1);
    end
    n_vec++;
    if (rq[0].size() != 1) begin
      n_miss++; $display("FAIL stall_pending: got %0d want 1", rq[0].size());
    end
  endtask

  task automatic ce_run(input bit toggle);
    do_reset(); busy_len = 2; got.delete(); n_acc = 0; n_ven = 0;
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) rq[i].push_back(pat[i][k]);
    for (int c = 0; c < 200 && (n_acc < 3 * N || m_phase != 2); c++) begin
      ce = toggle ? (c % 2 == 0) : 1'b1;
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL ce%0d cyc %0d: dut %h model %h", toggle, c, obs_vec(), exp_vec());
      end
      if (|req_ready) n_acc++;
      if (ce && gpu_op_valid) begin
        n_ven++; got.push_back(gpu_op);
      end
      tick_post();
    end
    ce = 1'b1;
    n_vec++;
    if (n_acc != 3 * N || n_ven != n_acc) begin
      n_miss++; $display("FAIL ce%0d_pulses: accepts %0d valid-cycles %0d want %0d each", toggle, n_acc, n_ven, 3 * N);
    end
  endtask

  task automatic test_ce_toggle();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        pat[i][k].op   = rand_op();
        pat[i][k].last = (k == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    ce_run(1'b0);
    got_a = got;
    ce_run(1'b1);
    n_vec++;
    if (got.size() != got_a.size()) begin
      n_miss++; $display("FAIL ce_len: got %0d want %0d", got.size(), got_a.size());
    end
    for (int k = 0; k < got.size() && k < got_a.size(); k++) begin
      n_vec++;
      if (got[k] !== got_a[k]) begin
        n_miss++; $display("FAIL ce_op %0d: got %h want %h", k, got[k], got_a[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p = -1;
    do_reset(); ce = 1'b1; busy_len = 6;
    push_op(1, 1'b0);
    for (int c = 0; c < 20 && p < 0; c++) begin
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL rstmid cyc %0d: dut %h model %h", c, obs_vec(), exp_vec());
      end
      if (gpu_op_valid) p = c;
      tick_post();
    end
    n_vec++;
    if (p < 0) begin
      n_miss++; $display("FAIL rstmid_pulse: got none want pulse within 20 cycles");
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gpu_op_valid, frame_done} !== 2'b00 || gpu_op !== gpu_op_t'('0)) begin
      n_miss++; $display("FAIL rstmid_async: got v=%b fd=%b op=%h want 0 0 0", gpu_op_valid, frame_done, gpu_op);
    end
    for (int i = 0; i < N; i++) rq[i].delete();
    m_reset(); gpu_busy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) push_op(i, 1'b0);
    tick_pre();
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_miss++; $display("FAIL rstmid_first: got %b want 001", req_ready);
    end
    tick_post();
    for (int c = 0; c < 10; c++) begin
      tick_pre();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL rstmid_after cyc %0d: dut %h model %h", c, obs_vec(), exp_vec());
      end
      tick_post();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_miss = 0; g_last = N - 1;
    test_reset();
    test_round_robin();
    test_single();
    test_swap();
    test_stall();
    test_ce_toggle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
